// File: rtl/mips_avalon_bridge.sv
// mips_avalon_bridge
//   Puts a multi-cycle Harvard MIPS core onto a single Avalon-MM master port.
//   Each instruction goes through the same sequence:
//     FETCH -> DECODE -> (DRD | DWR)? -> COMMIT
//   COMMIT pulses the core's clock enable for one cycle.
//   A stalled request that exceeds TIMEOUT_CYCLES is abandoned. The bridge
//   then latches bus_error and parks in HALT.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   cpu_*               core side: PC, IR, data address/controls, DR, clock enable
//   avm_*               Avalon-MM master (all request signals registered)
//   bus_error           sticky stall-timeout flag
//   halted              high in HALT (core inactive or bus error)
//   instr_count         saturating count of committed instructions
//   dbg_state           current FSM state, for observation only
//
// Handshake: a request (avm_read or avm_write) and its address, byteenable and
// write data stay constant while avm_waitrequest=1. The request completes in
// the first cycle it is high with avm_waitrequest=0; read data is taken in
// that same cycle.
module mips_avalon_bridge #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 32
) (
  input  logic                clk,
  input  logic                reset,
  output logic                cpu_clk_enable,
  input  logic                cpu_active,
  input  logic [ADDR_W-1:0]   cpu_instr_address,
  output logic [DATA_W-1:0]   cpu_instr_readdata,
  input  logic [ADDR_W-1:0]   cpu_data_address,
  input  logic                cpu_data_read,
  input  logic                cpu_data_write,
  input  logic [DATA_W-1:0]   cpu_data_writedata,
  input  logic [DATA_W/8-1:0] cpu_data_byteenable,
  output logic [DATA_W-1:0]   cpu_data_readdata,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest,
  output logic                bus_error,
  output logic                halted,
  output logic [CNT_W-1:0]    instr_count,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_DRD    = 3'd2,
    ST_DWR    = 3'd3,
    ST_COMMIT = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam int BE_W    = DATA_W / 8;
  localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Stall count seen in the cycle that times out (the TIMEOUT_CYCLES-th stall).
  localparam logic [STALL_W-1:0] STALL_LAST =
    STALL_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BE_W - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   dr_q, dr_d;
  logic [ADDR_W-1:0]   avm_address_q, avm_address_d;
  logic                avm_read_q, avm_read_d;
  logic                avm_write_q, avm_write_d;
  logic [BE_W-1:0]     avm_be_q, avm_be_d;
  logic [DATA_W-1:0]   avm_wdata_q, avm_wdata_d;
  logic                bus_error_q, bus_error_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic                timeout_hit;

  // Only meaningful while a request is outstanding. The stall counter
  // restarts at every request launch.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && avm_waitrequest && (stall_q == STALL_LAST);

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    dr_d          = dr_q;
    avm_address_d = avm_address_q;
    avm_read_d    = avm_read_q;
    avm_write_d   = avm_write_q;
    avm_be_d      = avm_be_q;
    avm_wdata_d   = avm_wdata_q;
    bus_error_d   = bus_error_q;
    cnt_d         = cnt_q;
    stall_d       = stall_q;

    case (state_q)
      ST_FETCH: begin
        if (!avm_read_q) begin
          // Only reached straight out of reset: launch the first fetch.
          avm_read_d    = 1'b1;
          avm_address_d = cpu_instr_address & ALIGN_MASK;
          avm_be_d      = '1;
          stall_d       = '0;
        end else if (avm_waitrequest) begin
          if (timeout_hit) begin
            avm_read_d  = 1'b0;
            bus_error_d = 1'b1;
            state_d     = ST_HALT;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
        end else begin
          ir_d       = avm_readdata;
          avm_read_d = 1'b0;
          state_d    = ST_DECODE;
        end
      end

      ST_DECODE: begin
        // A load wins over a simultaneous store.
        if (cpu_data_read) begin
          avm_read_d    = 1'b1;
          avm_address_d = cpu_data_address & ALIGN_MASK;
          avm_be_d      = '1;
          stall_d       = '0;
          state_d       = ST_DRD;
        end else if (cpu_data_write) begin
          avm_write_d   = 1'b1;
          avm_address_d = cpu_data_address & ALIGN_MASK;
          avm_be_d      = cpu_data_byteenable;
          avm_wdata_d   = cpu_data_writedata;
          stall_d       = '0;
          state_d       = ST_DWR;
        end else begin
          state_d = ST_COMMIT;
        end
      end

      ST_DRD: begin
        if (avm_waitrequest) begin
          if (timeout_hit) begin
            avm_read_d  = 1'b0;
            bus_error_d = 1'b1;
            state_d     = ST_HALT;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
        end else begin
          dr_d       = avm_readdata;
          avm_read_d = 1'b0;
          state_d    = ST_COMMIT;
        end
      end

      ST_DWR: begin
        if (avm_waitrequest) begin
          if (timeout_hit) begin
            avm_write_d = 1'b0;
            bus_error_d = 1'b1;
            state_d     = ST_HALT;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
        end else begin
          avm_write_d = 1'b0;
          state_d     = ST_COMMIT;
        end
      end

      ST_COMMIT: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (!cpu_active) begin
          state_d = ST_HALT;
        end else begin
          // Launch the next fetch so it is on the bus in the first FETCH cycle.
          avm_read_d    = 1'b1;
          avm_address_d = cpu_instr_address & ALIGN_MASK;
          avm_be_d      = '1;
          stall_d       = '0;
          state_d       = ST_FETCH;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_FETCH;
      ir_q          <= '0;
      dr_q          <= '0;
      avm_address_q <= '0;
      avm_read_q    <= 1'b0;
      avm_write_q   <= 1'b0;
      avm_be_q      <= '0;
      avm_wdata_q   <= '0;
      bus_error_q   <= 1'b0;
      cnt_q         <= '0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      dr_q          <= dr_d;
      avm_address_q <= avm_address_d;
      avm_read_q    <= avm_read_d;
      avm_write_q   <= avm_write_d;
      avm_be_q      <= avm_be_d;
      avm_wdata_q   <= avm_wdata_d;
      bus_error_q   <= bus_error_d;
      cnt_q         <= cnt_d;
      stall_q       <= stall_d;
    end
  end

  assign cpu_clk_enable     = (state_q == ST_COMMIT);
  assign halted             = (state_q == ST_HALT);
  assign cpu_instr_readdata = ir_q;
  assign cpu_data_readdata  = dr_q;
  assign avm_address        = avm_address_q;
  assign avm_read           = avm_read_q;
  assign avm_write          = avm_write_q;
  assign avm_byteenable     = avm_be_q;
  assign avm_writedata      = avm_wdata_q;
  assign bus_error          = bus_error_q;
  assign instr_count        = cnt_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_mips_avalon_bridge.sv
// tb_mips_avalon_bridge
//   Bench for mips_avalon_bridge, built with TIMEOUT_CYCLES=8 and CNT_W=2.
//   The slave is behavioural:
//     - word memory held in an associative array
//     - optional stall of N cycles on one chosen address
//     - optional permanently stuck waitrequest
//   A monitor records every accepted bus transfer as {write, be, addr, data}.
//   Tasks push the transfers they expect and compare them in order.
//   All inputs are driven, and all outputs sampled, on the falling edge.
module tb_mips_avalon_bridge;

  localparam int EW = 69;  // {write, be[3:0], addr[31:0], data[31:0]}

  logic        clk;
  logic        reset;
  logic        cpu_clk_enable;
  logic        cpu_active;
  logic [31:0] cpu_instr_address;
  logic [31:0] cpu_instr_readdata;
  logic [31:0] cpu_data_address;
  logic        cpu_data_read;
  logic        cpu_data_write;
  logic [31:0] cpu_data_writedata;
  logic [3:0]  cpu_data_byteenable;
  logic [31:0] cpu_data_readdata;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        bus_error;
  logic        halted;
  logic [1:0]  instr_count;
  logic [2:0]  dbg_state;

  mips_avalon_bridge #(
    .DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(8), .CNT_W(2)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_clk_enable(cpu_clk_enable), .cpu_active(cpu_active),
    .cpu_instr_address(cpu_instr_address), .cpu_instr_readdata(cpu_instr_readdata),
    .cpu_data_address(cpu_data_address), .cpu_data_read(cpu_data_read),
    .cpu_data_write(cpu_data_write), .cpu_data_writedata(cpu_data_writedata),
    .cpu_data_byteenable(cpu_data_byteenable), .cpu_data_readdata(cpu_data_readdata),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .bus_error(bus_error), .halted(halted), .instr_count(instr_count),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  logic [31:0] mem [logic [31:0]];
  logic        stuck;
  logic [31:0] stall_addr;
  int          stall_n;
  int          wait_left;

  assign avm_waitrequest = (avm_read || avm_write) &&
                           (stuck || (avm_address == stall_addr && wait_left != 0));

  always_comb begin
    avm_readdata = 32'hDEAD_BEEF;
    if (mem.exists(avm_address)) avm_readdata = mem[avm_address];
  end

  // Reload the stall budget whenever the bus is idle or a transfer completes.
  always @(posedge clk) begin
    if (!(avm_read || avm_write) || !avm_waitrequest) wait_left <= stall_n;
    else if (wait_left > 0) wait_left <= wait_left - 1;
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  int n_checks;
  int n_fail;

  always @(negedge clk) begin
    if (reset && (avm_read || avm_write) && !avm_waitrequest)
      obs_q.push_back({avm_write, avm_byteenable, avm_address,
                       avm_write ? avm_writedata : avm_readdata});
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle(input logic [31:0] pc);
    cpu_active          = 1'b1;
    cpu_instr_address   = pc;
    cpu_data_address    = 32'h0;
    cpu_data_read       = 1'b0;
    cpu_data_write      = 1'b0;
    cpu_data_writedata  = 32'h0;
    cpu_data_byteenable = 4'h0;
  endtask

  // Holds reset for two cycles, then releases it on a falling edge.
  task automatic do_reset();
    reset   = 1'b0;
    stuck   = 1'b0;
    stall_n = 0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    obs_q.delete();
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_nop();
    logic [7:0] pulse_mask;
    logic [7:0] read_mask;
    logic [EW-1:0] e;
    logic [EW-1:0] o;
    pulse_mask = '0;
    read_mask  = '0;
    mem[32'h10] = 32'h0000_0000;
    drive_idle(32'h10);
    do_reset();
    exp_q.push_back({1'b0, 4'hF, 32'h10, 32'h0});
    exp_q.push_back({1'b0, 4'hF, 32'h10, 32'h0});
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      pulse_mask[i] = cpu_clk_enable;
      read_mask[i]  = avm_read;
      if (i == 1) begin
        n_checks++;
        if (avm_address !== 32'h10 || avm_byteenable !== 4'hF) begin
          n_fail++;
          $display("FAIL nop_fetch_addr: got %h be %h, want 00000010 be f", avm_address, avm_byteenable);
        end
      end
      if (i == 2) begin
        n_checks++;
        if (dbg_state !== 3'd1 || avm_read !== 1'b0 || avm_write !== 1'b0) begin
          n_fail++;
          $display("FAIL nop_decode: state %0d rd %b wr %b, want 1 0 0", dbg_state, avm_read, avm_write);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (instr_count !== 2'd1) begin
          n_fail++;
          $display("FAIL nop_count1: got %0d want 1", instr_count);
        end
      end
    end
    // Pulse during the third cycle after release (commit lands on the third edge
    // after the issuing edge), then every 3 cycles; fetches every 3 cycles.
    n_checks++;
    if (pulse_mask !== 8'b0100_1000) begin
      n_fail++;
      $display("FAIL nop_pulse_timing: got %b want 01001000", pulse_mask);
    end
    n_checks++;
    if (read_mask !== 8'b1001_0010) begin
      n_fail++;
      $display("FAIL nop_read_timing: got %b want 10010010", read_mask);
    end
    n_checks++;
    if (instr_count !== 2'd2) begin
      n_fail++;
      $display("FAIL nop_count2: got %0d want 2", instr_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL nop_sb: no transfer, want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL nop_sb: got %h want %h", o, e);
        end
      end
    end
  endtask

  task automatic test_load();
    int hold;
    int last_rd;
    int pulse_at;
    logic [EW-1:0] e;
    logic [EW-1:0] o;
    hold = 0; last_rd = -1; pulse_at = -1;
    mem[32'h20] = 32'h8C02_0024;
    mem[32'h24] = 32'hCAFE_F00D;
    drive_idle(32'h20);
    cpu_data_read    = 1'b1;
    cpu_data_address = 32'h24;
    do_reset();
    stall_addr = 32'h24;
    stall_n    = 5;
    exp_q.push_back({1'b0, 4'hF, 32'h20, 32'h8C02_0024});
    exp_q.push_back({1'b0, 4'hF, 32'h24, 32'hCAFE_F00D});
    for (int i = 1; i < 30 && pulse_at < 0; i++) begin
      @(negedge clk);
      if (avm_read && avm_address == 32'h24) begin
        hold++;
        last_rd = i;
      end
      if (cpu_clk_enable) pulse_at = i;
    end
    n_checks++;
    if (hold !== 6) begin
      n_fail++;
      $display("FAIL load_hold_cycles: got %0d want 6", hold);
    end
    n_checks++;
    if (pulse_at !== last_rd + 1) begin
      n_fail++;
      $display("FAIL load_commit_timing: pulse at %0d want %0d", pulse_at, last_rd + 1);
    end
    n_checks++;
    if (cpu_data_readdata !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL load_dr: got %h want cafef00d", cpu_data_readdata);
    end
    n_checks++;
    if (cpu_instr_readdata !== 32'h8C02_0024) begin
      n_fail++;
      $display("FAIL load_ir: got %h want 8c020024", cpu_instr_readdata);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL load_sb: no transfer, want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL load_sb: got %h want %h", o, e);
        end
      end
    end
    stall_n = 0;
    cpu_data_read = 1'b0;
  endtask

  // Reset applied after activity has left IR, DR and the counter non-zero.
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (avm_read !== 1'b0 || avm_write !== 1'b0 || avm_address !== 32'h0 ||
        avm_byteenable !== 4'h0 || avm_writedata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_avm: rd %b wr %b addr %h be %h wd %h, want all 0",
               avm_read, avm_write, avm_address, avm_byteenable, avm_writedata);
    end
    n_checks++;
    if (cpu_instr_readdata !== 32'h0 || cpu_data_readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_ir_dr: ir %h dr %h, want 0 0", cpu_instr_readdata, cpu_data_readdata);
    end
    n_checks++;
    if (cpu_clk_enable !== 1'b0 || bus_error !== 1'b0 || halted !== 1'b0 ||
        instr_count !== 2'd0 || dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ce %b err %b halt %b cnt %0d state %0d, want 0 0 0 0 0",
               cpu_clk_enable, bus_error, halted, instr_count, dbg_state);
    end
  endtask

  task automatic test_store(input logic both);
    int wr_cycles;
    int wr_accepted;
    int pulses;
    logic [EW-1:0] e;
    logic [EW-1:0] o;
    wr_cycles = 0; wr_accepted = 0; pulses = 0;
    mem[32'h30] = 32'hAC02_1002;
    mem[32'h1000] = 32'h55AA_55AA;
    drive_idle(32'h30);
    cpu_data_write      = 1'b1;
    cpu_data_read       = both;
    cpu_data_address    = 32'h1002;
    cpu_data_writedata  = 32'h1234_0000;
    cpu_data_byteenable = 4'b1100;
    do_reset();
    exp_q.push_back({1'b0, 4'hF, 32'h30, 32'hAC02_1002});
    if (both) exp_q.push_back({1'b0, 4'hF, 32'h1000, 32'h55AA_55AA});
    else      exp_q.push_back({1'b1, 4'b1100, 32'h1000, 32'h1234_0000});
    for (int i = 1; i < 30 && pulses == 0; i++) begin
      @(negedge clk);
      if (avm_write) wr_cycles++;
      if (avm_write && !avm_waitrequest) wr_accepted++;
      if (cpu_clk_enable) pulses++;
    end
    n_checks++;
    if (wr_accepted !== (both ? 0 : 1) || wr_cycles !== (both ? 0 : 1)) begin
      n_fail++;
      $display("FAIL store_write_count(both=%0b): cycles %0d accepted %0d, want %0d",
               both, wr_cycles, wr_accepted, both ? 0 : 1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL store_sb(both=%0b): no transfer, want %h", both, e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL store_sb(both=%0b): got %h want %h", both, o, e);
        end
      end
    end
    drive_idle(32'h30);
  endtask

  task automatic test_timeout();
    int reads;
    int pulses;
    reads = 0; pulses = 0;
    drive_idle(32'h10);
    do_reset();
    stuck = 1'b1;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      if (avm_read) reads++;
      if (cpu_clk_enable) pulses++;
    end
    n_checks++;
    if (reads !== 8) begin
      n_fail++;
      $display("FAIL timeout_req_cycles: got %0d want 8", reads);
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL timeout_no_commit: got %0d pulses want 0", pulses);
    end
    n_checks++;
    if (bus_error !== 1'b1 || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_flags: err %b halt %b, want 1 1", bus_error, halted);
    end
    stuck = 1'b0;
  endtask

  task automatic test_halt();
    int reads;
    int pulses;
    reads = 0; pulses = 0;
    mem[32'h10] = 32'h0000_0000;
    drive_idle(32'h10);
    cpu_active = 1'b0;
    do_reset();
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      if (avm_read || avm_write) reads++;
      if (cpu_clk_enable) pulses++;
    end
    n_checks++;
    if (reads !== 1 || pulses !== 1) begin
      n_fail++;
      $display("FAIL halt_activity: bus cycles %0d pulses %0d, want 1 1", reads, pulses);
    end
    n_checks++;
    if (halted !== 1'b1 || bus_error !== 1'b0 || instr_count !== 2'd1) begin
      n_fail++;
      $display("FAIL halt_flags: halt %b err %b cnt %0d, want 1 0 1", halted, bus_error, instr_count);
    end
  endtask

  task automatic test_reset_mid_write();
    int guard;
    guard = 0;
    mem[32'h30] = 32'hAC02_1002;
    mem[32'h40] = 32'h0000_0000;
    drive_idle(32'h30);
    cpu_data_write      = 1'b1;
    cpu_data_address    = 32'h1002;
    cpu_data_writedata  = 32'h1234_0000;
    cpu_data_byteenable = 4'b1100;
    do_reset();
    stall_addr = 32'h1000;
    stall_n    = 20;
    while (avm_write !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (avm_write !== 1'b1) begin
      n_fail++;
      $display("FAIL midwr_reach_dwr: avm_write %b want 1 within 20 cycles", avm_write);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (avm_write !== 1'b0) begin
      n_fail++;
      $display("FAIL midwr_drop: avm_write %b want 0 during reset", avm_write);
    end
    stall_n = 0;
    drive_idle(32'h40);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (avm_read !== 1'b1 || avm_address !== 32'h40 || avm_write !== 1'b0) begin
      n_fail++;
      $display("FAIL midwr_refetch: rd %b wr %b addr %h, want 1 0 00000040", avm_read, avm_write, avm_address);
    end
  endtask

  task automatic test_saturate();
    int pulses;
    logic [1:0] want;
    pulses = 0;
    mem[32'h10] = 32'h0000_0000;
    drive_idle(32'h10);
    do_reset();
    for (int i = 1; i < 40 && pulses < 5; i++) begin
      @(negedge clk);
      if (cpu_clk_enable) begin
        pulses++;
        @(negedge clk);
        want = (pulses >= 3) ? 2'd3 : 2'(pulses);
        n_checks++;
        if (instr_count !== want) begin
          n_fail++;
          $display("FAIL sat_count_after_%0d: got %0d want %0d", pulses, instr_count, want);
        end
      end
    end
    n_checks++;
    if (pulses !== 5) begin
      n_fail++;
      $display("FAIL sat_pulses: got %0d want 5 within 40 cycles", pulses);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b0;
    stuck      = 1'b0;
    stall_n    = 0;
    stall_addr = 32'hFFFF_FFFF;
    drive_idle(32'h0);
    test_nop();
    test_load();
    test_reset();
    test_store(1'b0);
    test_store(1'b1);
    test_timeout();
    test_halt();
    test_reset_mid_write();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
